// File: rtl/decode_stage_if.sv
// Fetch-side and execute-side handshake bundle for decode_stage.
interface decode_stage_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_pc;
  logic [31:0]       fetch_insn;
  logic              dec_valid;
  logic              dec_ready;
  logic [ADDR_W-1:0] dec_pc;
  logic [7:0]        dec_opcode;
  logic [3:0]        dec_rd;
  logic [3:0]        dec_rs1;
  logic [3:0]        dec_rs2;
  logic [31:0]       dec_imm;
  logic              dec_illegal;
  logic [CNT_W-1:0]  dec_count;

  modport master (
    output fetch_valid, fetch_pc, fetch_insn, dec_ready,
    input  fetch_ready, dec_valid, dec_pc, dec_opcode, dec_rd, dec_rs1,
           dec_rs2, dec_imm, dec_illegal, dec_count
  );

  modport slave (
    input  fetch_valid, fetch_pc, fetch_insn, dec_ready,
    output fetch_ready, dec_valid, dec_pc, dec_opcode, dec_rd, dec_rs1,
           dec_rs2, dec_imm, dec_illegal, dec_count
  );
endinterface

// File: rtl/decode_stage.sv
// Instruction decode stage: cracks fetch words into fields, reassembles
// two-word immediates, and presents one registered result to execute.
module decode_stage #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  decode_stage_if.slave bus
);
  typedef enum logic {S_FIRST, S_IMM} state_t;

  state_t state, state_next;

  logic              accept, handover;
  logic              load_single, load_imm, latch_hdr;
  logic [7:0]        op;
  logic [31:0]       sext12;
  logic              two_word, illegal;
  logic [31:0]       imm;

  logic [ADDR_W-1:0] hdr_pc;
  logic [7:0]        hdr_op;
  logic [3:0]        hdr_rd, hdr_rs1, hdr_rs2;

  logic              out_valid;
  logic [ADDR_W-1:0] out_pc;
  logic [7:0]        out_op;
  logic [3:0]        out_rd, out_rs1, out_rs2;
  logic [31:0]       out_imm;
  logic              out_ill;
  logic [CNT_W-1:0]  cnt;

  assign bus.fetch_ready = !reset && !flush && (!out_valid || bus.dec_ready);
  assign accept          = bus.fetch_valid && bus.fetch_ready;
  assign handover        = out_valid && bus.dec_ready;

  assign op     = bus.fetch_insn[31:24];
  assign sext12 = {{20{bus.fetch_insn[11]}}, bus.fetch_insn[11:0]};

  always_comb begin
    two_word = 1'b0;
    illegal  = 1'b0;
    imm      = '0;
    case (op) inside
      8'h00:          imm = '0;
      [8'h01:8'h1F]:  imm = '0;
      [8'h20:8'h4F]:  imm = sext12;
      [8'h60:8'h6F]:  imm = {sext12[29:0], 2'b00};
      8'h50, 8'h51:   two_word = 1'b1;
      default:        illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_next  = state;
    load_single = 1'b0;
    load_imm    = 1'b0;
    latch_hdr   = 1'b0;
    if (accept) begin
      case (state)
        S_FIRST: begin
          if (two_word) begin
            latch_hdr  = 1'b1;
            state_next = S_IMM;
          end else begin
            load_single = 1'b1;
          end
        end
        S_IMM: begin
          load_imm   = 1'b1;
          state_next = S_FIRST;
        end
        default: state_next = S_FIRST;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) state <= S_FIRST;
    else                state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      hdr_pc  <= '0;
      hdr_op  <= '0;
      hdr_rd  <= '0;
      hdr_rs1 <= '0;
      hdr_rs2 <= '0;
    end else if (latch_hdr) begin
      hdr_pc  <= bus.fetch_pc;
      hdr_op  <= op;
      hdr_rd  <= bus.fetch_insn[23:20];
      hdr_rs1 <= bus.fetch_insn[19:16];
      hdr_rs2 <= bus.fetch_insn[15:12];
    end
  end

  // A load in the same cycle as a hand-over overwrites the register directly,
  // which is what gives back-to-back issue without a bubble.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_op    <= '0;
      out_rd    <= '0;
      out_rs1   <= '0;
      out_rs2   <= '0;
      out_imm   <= '0;
      out_ill   <= 1'b0;
    end else if (load_single) begin
      out_valid <= 1'b1;
      out_pc    <= bus.fetch_pc;
      out_op    <= op;
      out_rd    <= bus.fetch_insn[23:20];
      out_rs1   <= bus.fetch_insn[19:16];
      out_rs2   <= bus.fetch_insn[15:12];
      out_imm   <= imm;
      out_ill   <= illegal;
    end else if (load_imm) begin
      out_valid <= 1'b1;
      out_pc    <= hdr_pc;
      out_op    <= hdr_op;
      out_rd    <= hdr_rd;
      out_rs1   <= hdr_rs1;
      out_rs2   <= hdr_rs2;
      out_imm   <= bus.fetch_insn;
      out_ill   <= 1'b0;
    end else if (handover) begin
      out_valid <= 1'b0;
    end
  end

  // Counter survives flush; only reset clears it.
  always_ff @(posedge clk) begin
    if (reset)         cnt <= '0;
    else if (handover) cnt <= cnt + 1'b1;
  end

  assign bus.dec_valid   = out_valid;
  assign bus.dec_pc      = out_pc;
  assign bus.dec_opcode  = out_op;
  assign bus.dec_rd      = out_rd;
  assign bus.dec_rs1     = out_rs1;
  assign bus.dec_rs2     = out_rs2;
  assign bus.dec_imm     = out_imm;
  assign bus.dec_illegal = out_ill;
  assign bus.dec_count   = cnt;
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// stream compared against an instruction-level reference model.
module tb_decode_stage;
  logic clk = 1'b0;
  logic reset, flush;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  decode_stage_if #(.ADDR_W(32), .CNT_W(4)) bus ();

  decode_stage #(.ADDR_W(32), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  // reference model state
  logic        m_valid, m_pend, m_ill;
  logic [31:0] m_pc, m_imm, p_pc;
  logic [7:0]  m_op, p_op;
  logic [3:0]  m_rd, m_rs1, m_rs2, p_rd, p_rs1, p_rs2;
  logic [3:0]  m_cnt;

  function automatic logic [31:0] ref_imm(input logic [31:0] insn);
    int unsigned o;
    logic [31:0] lo;
    o  = insn >> 24;
    lo = insn & 32'hFFF;
    if (lo >= 32'd2048) lo = lo | 32'hFFFFF000;
    if (o >= 8'h20 && o <= 8'h4F) return lo;
    if (o >= 8'h60 && o <= 8'h6F) return lo * 4;
    return 32'd0;
  endfunction

  function automatic logic ref_illegal(input logic [31:0] insn);
    int unsigned o;
    o = insn >> 24;
    return !(o <= 8'h4F || o == 8'h50 || o == 8'h51 || (o >= 8'h60 && o <= 8'h6F));
  endfunction

  function automatic logic ref_two(input logic [31:0] insn);
    return (insn >> 24) == 8'h50 || (insn >> 24) == 8'h51;
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] insn,
                       input logic r, input logic f, input logic rs);
    bus.fetch_valid = v;
    bus.fetch_pc    = pc;
    bus.fetch_insn  = insn;
    bus.dec_ready   = r;
    flush           = f;
    reset           = rs;
    #1;
  endtask

  task automatic tick();
    logic exp_ready, acc, hand;
    @(posedge clk);
    exp_ready = !reset && !flush && (!m_valid || bus.dec_ready);
    acc  = bus.fetch_valid && exp_ready;
    hand = m_valid && bus.dec_ready;
    if (reset) begin
      m_valid = 0; m_pend = 0; m_cnt = 0;
      m_pc = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_ill = 0;
    end else if (flush) begin
      if (hand) m_cnt = m_cnt + 1;
      m_valid = 0; m_pend = 0;
      m_pc = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0; m_imm = 0; m_ill = 0;
    end else begin
      if (hand) begin
        m_cnt = m_cnt + 1;
        m_valid = 0;
      end
      if (acc) begin
        if (m_pend) begin
          m_valid = 1; m_pend = 0;
          m_pc = p_pc; m_op = p_op; m_rd = p_rd; m_rs1 = p_rs1; m_rs2 = p_rs2;
          m_imm = bus.fetch_insn; m_ill = 0;
        end else if (ref_two(bus.fetch_insn)) begin
          m_pend = 1;
          p_pc = bus.fetch_pc; p_op = bus.fetch_insn[31:24]; p_rd = bus.fetch_insn[23:20];
          p_rs1 = bus.fetch_insn[19:16]; p_rs2 = bus.fetch_insn[15:12];
        end else begin
          m_valid = 1;
          m_pc = bus.fetch_pc; m_op = bus.fetch_insn[31:24]; m_rd = bus.fetch_insn[23:20];
          m_rs1 = bus.fetch_insn[19:16]; m_rs2 = bus.fetch_insn[15:12];
          m_imm = ref_imm(bus.fetch_insn); m_ill = ref_illegal(bus.fetch_insn);
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 1);
    checks++;
    if (bus.fetch_ready !== 1'b0) begin
      failures++; $display("FAIL reset_ready got=%0b exp=0", bus.fetch_ready);
    end
    tick();
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.dec_count !== 4'd0 || bus.dec_imm !== 32'd0 || bus.dec_pc !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs got valid=%0b count=%0d imm=%h pc=%h exp all 0",
               bus.dec_valid, bus.dec_count, bus.dec_imm, bus.dec_pc);
    end
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.fetch_ready !== 1'b1) begin
      failures++; $display("FAIL release_ready got=%0b exp=1", bus.fetch_ready);
    end
    tick();
  endtask

  task automatic test_stream();
    drive(1, 32'h10, 32'h01312000, 1, 0, 0); tick();
    drive(1, 32'h14, 32'h20410FFF, 1, 0, 0);
    checks++;
    if (bus.dec_valid !== 1 || bus.dec_opcode !== 8'h01 || bus.dec_rd !== 4'd3 || bus.dec_rs1 !== 4'd1 ||
        bus.dec_rs2 !== 4'd2 || bus.dec_imm !== 32'd0 || bus.dec_pc !== 32'h10) begin
      failures++;
      $display("FAIL stream_add got v=%0b op=%h rd=%0d rs1=%0d rs2=%0d imm=%h pc=%h exp 1/01/3/1/2/0/10",
               bus.dec_valid, bus.dec_opcode, bus.dec_rd, bus.dec_rs1, bus.dec_rs2, bus.dec_imm, bus.dec_pc);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.dec_valid !== 1 || bus.dec_opcode !== 8'h20 || bus.dec_rd !== 4'd4 || bus.dec_imm !== 32'hFFFFFFFF) begin
      failures++;
      $display("FAIL stream_addi got v=%0b op=%h rd=%0d imm=%h exp 1/20/4/ffffffff",
               bus.dec_valid, bus.dec_opcode, bus.dec_rd, bus.dec_imm);
    end
    tick();
    checks++;
    if (bus.dec_count !== 4'd2 || bus.dec_valid !== 1'b0) begin
      failures++; $display("FAIL stream_count got cnt=%0d v=%0b exp 2/0", bus.dec_count, bus.dec_valid);
    end
  endtask

  task automatic test_two_word();
    drive(1, 32'h100, 32'h50500000, 1, 0, 0); tick();
    drive(1, 32'h104, 32'hDEADBEEF, 1, 0, 0);
    checks++;
    if (bus.dec_valid !== 1'b0 || bus.fetch_ready !== 1'b1) begin
      failures++; $display("FAIL movi_header got v=%0b rdy=%0b exp 0/1", bus.dec_valid, bus.fetch_ready);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.dec_valid !== 1 || bus.dec_pc !== 32'h100 || bus.dec_rd !== 4'd5 || bus.dec_opcode !== 8'h50 ||
        bus.dec_imm !== 32'hDEADBEEF || bus.dec_illegal !== 1'b0) begin
      failures++;
      $display("FAIL movi_out got v=%0b pc=%h rd=%0d op=%h imm=%h ill=%0b exp 1/100/5/50/deadbeef/0",
               bus.dec_valid, bus.dec_pc, bus.dec_rd, bus.dec_opcode, bus.dec_imm, bus.dec_illegal);
    end
    tick();
  endtask

  task automatic test_stall();
    drive(1, 32'h200, 32'h60012004, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h204, 32'h01000000, 0, 0, 0);
      checks++;
      if (bus.fetch_ready !== 0 || bus.dec_valid !== 1 || bus.dec_imm !== 32'h10 || bus.dec_pc !== 32'h200 ||
          bus.dec_opcode !== 8'h60) begin
        failures++;
        $display("FAIL stall_%0d got rdy=%0b v=%0b imm=%h pc=%h op=%h exp 0/1/10/200/60",
                 i, bus.fetch_ready, bus.dec_valid, bus.dec_imm, bus.dec_pc, bus.dec_opcode);
      end
      tick();
    end
    drive(0, 0, 0, 1, 0, 0); tick();
  endtask

  task automatic test_flush();
    drive(1, 32'h280, 32'h50700000, 1, 0, 0); tick();
    drive(1, 32'h284, 32'h12345678, 1, 1, 0);
    checks++;
    if (bus.fetch_ready !== 1'b0) begin
      failures++; $display("FAIL flush_ready got=%0b exp=0", bus.fetch_ready);
    end
    tick();
    drive(1, 32'h300, 32'h01000000, 1, 0, 0);
    checks++;
    if (bus.dec_valid !== 1'b0) begin
      failures++; $display("FAIL flush_no_output got v=%0b exp 0", bus.dec_valid);
    end
    tick();
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.dec_valid !== 1 || bus.dec_opcode !== 8'h01 || bus.dec_imm !== 32'd0 || bus.dec_pc !== 32'h300) begin
      failures++;
      $display("FAIL flush_next got v=%0b op=%h imm=%h pc=%h exp 1/01/0/300",
               bus.dec_valid, bus.dec_opcode, bus.dec_imm, bus.dec_pc);
    end
    tick();
  endtask

  task automatic test_illegal_wrap();
    drive(1, 32'h400, 32'hFF123ABC, 1, 0, 0); tick();
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.dec_valid !== 1 || bus.dec_illegal !== 1'b1 || bus.dec_imm !== 32'd0) begin
      failures++;
      $display("FAIL illegal got v=%0b ill=%0b imm=%h exp 1/1/0", bus.dec_valid, bus.dec_illegal, bus.dec_imm);
    end
    tick();
    for (int i = 0; i < 40 && !(m_cnt == 4'd15 && m_valid); i++) begin
      drive(1, 32'h500 + i * 4, 32'h00000000, 1, 0, 0); tick();
    end
    drive(0, 0, 0, 1, 0, 0);
    checks++;
    if (bus.dec_count !== 4'd15 || bus.dec_valid !== 1'b1) begin
      failures++; $display("FAIL wrap_pre got cnt=%0d v=%0b exp 15/1", bus.dec_count, bus.dec_valid);
    end
    tick();
    checks++;
    if (bus.dec_count !== 4'd0) begin
      failures++; $display("FAIL wrap got cnt=%0d exp 0", bus.dec_count);
    end
  endtask

  task automatic test_random();
    logic [31:0] insn, pc;
    logic        v, r, f, rs, exp_ready;
    int unsigned sel;
    pc = 32'h1000;
    for (int n = 0; n < 3000; n++) begin
      sel  = $urandom_range(0, 9);
      insn = $urandom;
      case (sel)
        0: insn[31:24] = 8'h00;
        1: insn[31:24] = 8'($urandom_range(8'h01, 8'h1F));
        2: insn[31:24] = 8'($urandom_range(8'h20, 8'h3F));
        3: insn[31:24] = 8'($urandom_range(8'h40, 8'h4F));
        4: insn[31:24] = 8'($urandom_range(8'h60, 8'h6F));
        5: insn[31:24] = 8'h50;
        6: insn[31:24] = 8'h51;
        7: insn[31:24] = 8'($urandom_range(8'h70, 8'hFF));
        default: ;
      endcase
      v  = ($urandom_range(0, 9) < 7);
      r  = ($urandom_range(0, 9) < 6);
      f  = ($urandom_range(0, 29) == 0);
      rs = ($urandom_range(0, 149) == 0);
      pc = pc + 4;
      drive(v, pc, insn, r, f, rs);
      exp_ready = !rs && !f && (!m_valid || r);
      checks++;
      if (bus.fetch_ready !== exp_ready) begin
        failures++; $display("FAIL rand_ready[%0d] got=%0b exp=%0b", n, bus.fetch_ready, exp_ready);
      end
      tick();
      checks++;
      if (bus.dec_valid !== m_valid || bus.dec_count !== m_cnt ||
          (m_valid && (bus.dec_pc !== m_pc || bus.dec_opcode !== m_op || bus.dec_rd !== m_rd ||
                       bus.dec_rs1 !== m_rs1 || bus.dec_rs2 !== m_rs2 || bus.dec_imm !== m_imm ||
                       bus.dec_illegal !== m_ill))) begin
        failures++;
        $display("FAIL rand_out[%0d] got v=%0b cnt=%0d pc=%h op=%h rd=%0d rs1=%0d rs2=%0d imm=%h ill=%0b exp v=%0b cnt=%0d pc=%h op=%h rd=%0d rs1=%0d rs2=%0d imm=%h ill=%0b",
                 n, bus.dec_valid, bus.dec_count, bus.dec_pc, bus.dec_opcode, bus.dec_rd, bus.dec_rs1,
                 bus.dec_rs2, bus.dec_imm, bus.dec_illegal, m_valid, m_cnt, m_pc, m_op, m_rd, m_rs1,
                 m_rs2, m_imm, m_ill);
      end
    end
  endtask

  initial begin
    m_valid = 0; m_pend = 0; m_cnt = 0; m_ill = 0;
    m_pc = 0; m_imm = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
    p_pc = 0; p_op = 0; p_rd = 0; p_rs1 = 0; p_rs2 = 0;
    test_reset();
    test_stream();
    test_two_word();
    test_stall();
    test_flush();
    test_illegal_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
